// File: rtl/qtree_bool_serializer_pkg.sv
// rtl/qtree_bool_serializer_pkg.sv - QTree_Bool word layout, frame type and FSM states
package qtree_bool_serializer_pkg;

  typedef logic [66:0] qtree_bool_t;
  typedef logic [15:0] ptr_qtree_bool_t;

  localparam logic [1:0] QNONE  = 2'd0;
  localparam logic [1:0] QVAL   = 2'd1;
  localparam logic [1:0] QNODE  = 2'd2;
  localparam logic [1:0] QERROR = 2'd3;

  localparam int VALID_BIT  = 0;
  localparam int TAG_LSB    = 1;
  localparam int VALUE_BIT  = 3;
  localparam int KIDS_LSB   = 3;
  localparam int KID_W      = 16;
  localparam int PTR_ADDR_W = 15;

  localparam qtree_bool_t QNONE_WORD  = {64'd0, QNONE, 1'b1};
  localparam qtree_bool_t QERROR_WORD = {64'd0, QERROR, 1'b1};

  typedef struct packed {
    logic [PTR_ADDR_W-1:0]     addr;
    ptr_qtree_bool_t [3:0]     kids;
    logic [2:0]                idx;
    qtree_bool_t               word;
  } frame_t;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_DESCEND, S_EMIT, S_EMIT_NULL
  } state_t;

  function automatic logic [1:0] tag_of(qtree_bool_t w);
    return w[TAG_LSB +: 2];
  endfunction

  // Outgoing words always carry valid=1; child pointers are heap-local, so they are dropped.
  function automatic qtree_bool_t emit_word(qtree_bool_t w);
    qtree_bool_t r;
    r = w;
    r[VALID_BIT] = 1'b1;
    if (tag_of(w) == QNODE) r[66:KIDS_LSB] = '0;
    return r;
  endfunction

endpackage

// File: rtl/qtree_bool_serializer_if.sv
// rtl/qtree_bool_serializer_if.sv - root input, heap read port and output stream of the serializer
interface qtree_bool_serializer_if #(
  parameter int ADDR_W = 15
);
  import qtree_bool_serializer_pkg::*;

  ptr_qtree_bool_t   result_data;
  logic              result_ready;
  logic              heap_rd_en;
  logic [ADDR_W-1:0] heap_rd_addr;
  qtree_bool_t       heap_rd_data;
  qtree_bool_t       o_QTree_Bool_tdata;
  logic              o_QTree_Bool_tlast;
  logic              o_QTree_Bool_tvalid;
  logic              o_QTree_Bool_tready;

  modport master (
    input  result_data, heap_rd_data, o_QTree_Bool_tready,
    output result_ready, heap_rd_en, heap_rd_addr,
           o_QTree_Bool_tdata, o_QTree_Bool_tlast, o_QTree_Bool_tvalid
  );

  modport slave (
    output result_data, heap_rd_data, o_QTree_Bool_tready,
    input  result_ready, heap_rd_en, heap_rd_addr,
           o_QTree_Bool_tdata, o_QTree_Bool_tlast, o_QTree_Bool_tvalid
  );

endinterface

// File: rtl/qtree_frame_stack.sv
// rtl/qtree_frame_stack.sv - LIFO of traversal frames with an in-place writable top entry
module qtree_frame_stack
  import qtree_bool_serializer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic          wr_top,
  input  frame_t        push_frame,
  input  frame_t        top_wr_frame,
  output frame_t        top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  frame_t        mem [DEPTH];
  logic [AW-1:0] top_idx;
  logic [AW-1:0] push_idx;

  assign top_idx  = AW'(depth - DW'(1));
  assign push_idx = AW'(depth);
  assign full     = (depth == DW'(DEPTH));
  assign empty    = (depth == '0);
  assign top      = mem[top_idx];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)              depth <= '0;
    else if (clear)            depth <= '0;
    else if (push && !full)    depth <= depth + DW'(1);
    else if (pop && !empty)    depth <= depth - DW'(1);
  end

  // Push and top rewrite may coincide: they address different entries.
  always_ff @(posedge clk) begin
    if (push && !full)    mem[push_idx] <= push_frame;
    if (wr_top && !empty) mem[top_idx]  <= top_wr_frame;
  end

endmodule

// File: rtl/qtree_bool_serializer.sv
// rtl/qtree_bool_serializer.sv - walks a QTree_Bool in heap memory and streams it out in post-order
module qtree_bool_serializer
  import qtree_bool_serializer_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int MAX_DEPTH = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      aresetn,
  qtree_bool_serializer_if.master   bus,
  output logic                      overflow
);

  localparam int DW = $clog2(MAX_DEPTH + 1);

  state_t          state;
  logic [1:0]      wait_cnt;
  logic            ready_q, rd_en_q, tvalid_q, tlast_q;
  qtree_bool_t     tdata_q;

  frame_t          top, push_frame, top_wr_frame;
  logic [DW-1:0]   depth;
  logic            full, empty, push, pop, wr_top, clear;

  ptr_qtree_bool_t child;
  qtree_bool_t     rd_word;
  logic            accept, at_end, word_done, is_node, last_frame;

  qtree_frame_stack #(.DEPTH(MAX_DEPTH), .DW(DW)) u_stack (
    .clk(clk), .aresetn(aresetn), .clear(clear), .push(push), .pop(pop),
    .wr_top(wr_top), .push_frame(push_frame), .top_wr_frame(top_wr_frame),
    .top(top), .depth(depth), .full(full), .empty(empty)
  );

  assign accept     = (state == S_IDLE) && bus.result_data[VALID_BIT] && empty;
  assign at_end     = (top.idx == 3'd4);
  // Children are visited q3 first so that q0 lands directly before its parent.
  assign child      = top.kids[2'd3 - top.idx[1:0]];
  assign word_done  = (state == S_WAIT) && (wait_cnt == 2'(RD_LAT - 1));
  assign rd_word    = bus.heap_rd_data[VALID_BIT] ? bus.heap_rd_data : QERROR_WORD;
  assign is_node    = (tag_of(rd_word) == QNODE);
  assign last_frame = (depth == DW'(1));

  always_comb begin
    push         = 1'b0;
    pop          = 1'b0;
    wr_top       = 1'b0;
    clear        = 1'b0;
    push_frame   = '0;
    top_wr_frame = top;
    case (state)
      S_IDLE: if (accept) begin
        push            = 1'b1;
        push_frame.addr = bus.result_data[15:1];
      end
      S_WAIT: if (word_done) begin
        wr_top            = 1'b1;
        top_wr_frame.word = rd_word;
        top_wr_frame.idx  = '0;
        top_wr_frame.kids = is_node ? rd_word[66:KIDS_LSB] : '0;
      end
      S_DESCEND: if (!at_end) begin
        wr_top           = 1'b1;
        top_wr_frame.idx = top.idx + 3'd1;
        if (child[VALID_BIT]) begin
          if (full) begin
            clear = 1'b1;
          end else begin
            push            = 1'b1;
            push_frame.addr = child[15:1];
          end
        end
      end
      S_EMIT: pop = bus.o_QTree_Bool_tready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ready_q  <= 1'b1;
      rd_en_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          ready_q <= 1'b0;
          rd_en_q <= 1'b1;
          state   <= S_READ;
        end
        S_READ: begin
          rd_en_q  <= 1'b0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!word_done) begin
            wait_cnt <= wait_cnt + 2'd1;
          end else if (is_node) begin
            state <= S_DESCEND;
          end else begin
            tvalid_q <= 1'b1;
            tdata_q  <= emit_word(rd_word);
            tlast_q  <= last_frame;
            state    <= S_EMIT;
          end
        end
        S_DESCEND: begin
          if (at_end) begin
            tvalid_q <= 1'b1;
            tdata_q  <= emit_word(top.word);
            tlast_q  <= last_frame;
            state    <= S_EMIT;
          end else if (!child[VALID_BIT]) begin
            tvalid_q <= 1'b1;
            tdata_q  <= QNONE_WORD;
            tlast_q  <= 1'b0;
            state    <= S_EMIT_NULL;
          end else if (full) begin
            overflow <= 1'b1;
            ready_q  <= 1'b1;
            state    <= S_IDLE;
          end else begin
            rd_en_q <= 1'b1;
            state   <= S_READ;
          end
        end
        S_EMIT: if (bus.o_QTree_Bool_tready) begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          if (last_frame) begin
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end else begin
            state <= S_DESCEND;
          end
        end
        S_EMIT_NULL: if (bus.o_QTree_Bool_tready) begin
          tvalid_q <= 1'b0;
          state    <= S_DESCEND;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.result_ready        = ready_q;
  assign bus.heap_rd_en          = rd_en_q;
  assign bus.heap_rd_addr        = rd_en_q ? top.addr[ADDR_W-1:0] : '0;
  assign bus.o_QTree_Bool_tvalid = tvalid_q;
  assign bus.o_QTree_Bool_tdata  = tdata_q;
  assign bus.o_QTree_Bool_tlast  = tlast_q;

endmodule

// File: tb/tb_qtree_bool_serializer.sv
// tb/tb_qtree_bool_serializer.sv - scoreboard bench with a post-order reference model over a heap array
module tb_qtree_bool_serializer;
  import qtree_bool_serializer_pkg::*;

  localparam int RD_LAT    = 2;
  localparam int MAX_DEPTH = 16;
  localparam int TIMEOUT   = 20000;

  typedef struct {
    logic [66:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic aresetn;
  logic overflow;
  always #5 clk = ~clk;

  qtree_bool_serializer_if #(.ADDR_W(15)) bus();

  qtree_bool_serializer #(.ADDR_W(15), .MAX_DEPTH(MAX_DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .aresetn(aresetn), .bus(bus), .overflow(overflow)
  );

  logic [66:0] heap [32768];
  logic [66:0] rd_d1 = '0;
  logic [66:0] rd_d2 = '0;
  int          rd_count = 0;

  always @(posedge clk) begin
    if (bus.heap_rd_en) begin
      rd_d1    <= heap[bus.heap_rd_addr];
      rd_count <= rd_count + 1;
    end
    rd_d2 <= rd_d1;
  end
  assign bus.heap_rd_data = (RD_LAT == 1) ? rd_d1 : rd_d2;

  beat_t exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    beat_cnt   = 0;
  bit    mon_en     = 1'b0;
  int    rdy_mode   = 0;
  int    next_addr;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Post-order with children q3..q0 equals the reverse of a pre-order that visits q0..q3.
  task automatic predict(input logic [15:0] root, output int reads);
    logic [15:0] work[$];
    logic [66:0] pre[$];
    logic [15:0] p;
    logic [66:0] w;
    reads = 0;
    work.push_back(root);
    while (work.size() > 0) begin
      p = work.pop_back();
      if (!p[0]) begin
        pre.push_back(67'h1);
      end else begin
        reads++;
        w = heap[p[15:1]];
        if (!w[0]) begin
          pre.push_back(67'h7);
        end else if (w[2:1] == 2'd2) begin
          pre.push_back(67'h5);
          for (int k = 3; k >= 0; k--) work.push_back(w[3 + 16*k +: 16]);
        end else begin
          pre.push_back(w);
        end
      end
    end
    for (int i = pre.size() - 1; i >= 0; i--) exp_q.push_back('{pre[i], (i == 0)});
  endtask

  initial begin : monitor
    bit          held;
    logic [66:0] hd;
    logic        hl;
    beat_t       b;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn || !mon_en) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_tvalid", bus.o_QTree_Bool_tvalid, 1);
          check("stall_tdata", bus.o_QTree_Bool_tdata, hd);
          check("stall_tlast", bus.o_QTree_Bool_tlast, hl);
        end
        if (bus.o_QTree_Bool_tvalid && bus.o_QTree_Bool_tready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_beat: got %0h expected no beat", bus.o_QTree_Bool_tdata);
          end else begin
            b = exp_q.pop_front();
            check("beat_tdata", bus.o_QTree_Bool_tdata, b.data);
            check("beat_tlast", bus.o_QTree_Bool_tlast, b.last);
          end
          beat_cnt++;
          held = 1'b0;
        end else if (bus.o_QTree_Bool_tvalid) begin
          held = 1'b1;
          hd   = bus.o_QTree_Bool_tdata;
          hl   = bus.o_QTree_Bool_tlast;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin : ready_driver
    logic [3:0] pat;
    int         pidx;
    pat  = 4'b1001;
    pidx = 0;
    bus.o_QTree_Bool_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.o_QTree_Bool_tready = 1'b1;
        1: begin
          bus.o_QTree_Bool_tready = pat[pidx];
          pidx = (pidx + 1) % 4;
        end
        default: bus.o_QTree_Bool_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check_reset_outputs(input string name, input logic exp_ovf);
    check({name, "_result_ready"}, bus.result_ready, 1);
    check({name, "_tvalid"}, bus.o_QTree_Bool_tvalid, 0);
    check({name, "_tlast"}, bus.o_QTree_Bool_tlast, 0);
    check({name, "_tdata"}, bus.o_QTree_Bool_tdata, 0);
    check({name, "_rd_en"}, bus.heap_rd_en, 0);
    check({name, "_rd_addr"}, bus.heap_rd_addr, 0);
    check({name, "_overflow"}, overflow, exp_ovf);
  endtask

  task automatic offer_root(input logic [15:0] root);
    @(negedge clk);
    bus.result_data = root;
    @(posedge clk);
    #1 bus.result_data = '0;
  endtask

  task automatic run_root(input logic [15:0] root, input string name);
    int exp_reads, exp_beats, start_reads, start_beats, cyc;
    predict(root, exp_reads);
    exp_beats   = exp_q.size();
    start_reads = rd_count;
    start_beats = beat_cnt;
    offer_root(root);
    cyc = 0;
    while (!(exp_q.size() == 0 && bus.result_ready && !bus.o_QTree_Bool_tvalid) && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_pending_beats"}, exp_q.size(), 0);
    check({name, "_heap_reads"}, rd_count - start_reads, exp_reads);
    check({name, "_beat_count"}, beat_cnt - start_beats, exp_beats);
    exp_q.delete();
  endtask

  task automatic build_tree(input int maxd, output logic [15:0] root);
    int          aq[$], dq[$];
    int          a, d;
    logic [95:0] r;
    logic [66:0] w;
    logic [15:0] kid;
    next_addr = 1000;
    root = {15'(next_addr), 1'b1};
    aq.push_back(next_addr++);
    dq.push_back(1);
    while (aq.size() > 0) begin
      a = aq.pop_front();
      d = dq.pop_front();
      r = {$urandom, $urandom, $urandom};
      w = r[66:0];
      if (d < maxd && $urandom_range(0, 1) == 1) begin
        w[2:0] = 3'b101;
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 4) != 0) begin
            kid = {15'(next_addr), 1'b1};
            aq.push_back(next_addr++);
            dq.push_back(d + 1);
          end else begin
            kid = {15'($urandom), 1'b0};
          end
          w[3 + 16*k +: 16] = kid;
        end
      end else begin
        case ($urandom_range(0, 3))
          0:       w[2:0] = {2'd1, 1'b1};
          1:       w[2:0] = {2'd0, 1'b1};
          2:       w[2:0] = {2'd3, 1'b1};
          default: w[0]   = 1'b0;
        endcase
      end
      heap[a] = w;
    end
  endtask

  initial begin : main
    logic [15:0] root;
    int          start_reads, start_beats, cyc;
    for (int i = 0; i < 32768; i++) heap[i] = '0;
    bus.result_data = '0;
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset", 0);
    aresetn = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle", 0);
    mon_en = 1'b1;

    heap[5] = 67'hB;
    run_root(16'h000B, "single_leaf");

    heap[1] = {16'h000B, 16'h0009, 16'h0007, 16'h0005, 3'b101};
    heap[2] = 67'h3;
    heap[3] = 67'hB;
    heap[4] = 67'h3;
    heap[5] = 67'hB;
    run_root(16'h0003, "node_four_leaves");

    rdy_mode = 1;
    run_root(16'h0003, "node_stalled");
    rdy_mode = 0;

    heap[20] = {16'h002F, 16'h002D, 16'h0000, 16'h002B, 3'b101};
    heap[21] = 67'hB;
    heap[22] = 67'h3;
    heap[23] = 67'hB;
    run_root(16'h0029, "null_q1");

    start_reads = rd_count;
    @(negedge clk);
    bus.result_data = 16'h000A;
    repeat (5) @(negedge clk);
    check("ignore_reads", rd_count - start_reads, 0);
    check("ignore_ready", bus.result_ready, 1);
    bus.result_data = '0;

    for (int i = 0; i < 17; i++)
      heap[100 + i] = {((i < 16) ? {15'(101 + i), 1'b1} : 16'h0000), 48'h0, 3'b101};
    start_reads = rd_count;
    start_beats = beat_cnt;
    offer_root({15'd100, 1'b1});
    cyc = 0;
    while (!overflow && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check("ovf_flag", overflow, 1);
    check("ovf_ready", bus.result_ready, 1);
    check("ovf_tvalid", bus.o_QTree_Bool_tvalid, 0);
    check("ovf_reads", rd_count - start_reads, 16);
    check("ovf_beats", beat_cnt - start_beats, 0);

    run_root(16'h000B, "after_overflow");
    check("ovf_sticky", overflow, 1);

    predict(16'h0003, start_reads);
    start_beats = beat_cnt;
    offer_root(16'h0003);
    cyc = 0;
    while (!(beat_cnt - start_beats >= 2 && bus.o_QTree_Bool_tvalid) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("midreset_third_beat_seen", beat_cnt - start_beats, 2);
    #2 aresetn = 1'b0;
    mon_en = 1'b0;
    #1 check_reset_outputs("midreset", 0);
    exp_q.delete();
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    run_root(16'h0003, "after_reset");

    rdy_mode = 2;
    for (int t = 0; t < 40; t++) begin
      build_tree($urandom_range(1, 4), root);
      run_root(root, "random_tree");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
